// File: rtl/axil_arbiter_rd_if.sv
// axil_arbiter_rd_if: request, grant and gated AR/R handshake signals around the read arbiter.
interface axil_arbiter_rd_if #(parameter int NUMBER_MASTER = 2);
  logic [NUMBER_MASTER-1:0] m_axil_arvalid;
  logic [NUMBER_MASTER-1:0] grant_rd;
  logic                     busy;
  logic                     xbar_arvalid;
  logic                     xbar_arready;
  logic                     xbar_rvalid;
  logic                     xbar_rready;
  logic                     s_axil_arvalid;
  logic                     s_axil_arready;
  logic                     s_axil_rvalid;
  logic                     s_axil_rready;
  modport master (
    input  m_axil_arvalid, xbar_arvalid, xbar_rready, s_axil_arready, s_axil_rvalid,
    output grant_rd, busy, xbar_arready, xbar_rvalid, s_axil_arvalid, s_axil_rready
  );
  modport slave (
    output m_axil_arvalid, xbar_arvalid, xbar_rready, s_axil_arready, s_axil_rvalid,
    input  grant_rd, busy, xbar_arready, xbar_rvalid, s_axil_arvalid, s_axil_rready
  );
endinterface

// File: rtl/axil_arbiter_rd.sv
// axil_arbiter_rd: round-robin read arbiter holding each grant for one full AR+R read.
module axil_arbiter_rd #(
  parameter int NUMBER_MASTER = 2
) (
  input logic              aclk,
  input logic              areset,
  axil_arbiter_rd_if.master bus
);
  localparam int N  = NUMBER_MASTER;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d, onehot;
  logic [IW-1:0] ptr_q, ptr_d, gidx, nptr, base, sel;
  logic          req, ar_hs, r_hs;
  int            idx;
  assign req   = |bus.m_axil_arvalid;
  assign ar_hs = bus.xbar_arvalid & bus.s_axil_arready;
  assign r_hs  = bus.s_axil_rvalid & bus.xbar_rready;
  // On a completing read the scan already starts past the just-served master.
  always_comb begin
    gidx = '0;
    idx  = 0;
    for (int i = 0; i < N; i++) if (grant_q[i]) gidx = IW'(i);
    nptr = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
    base = (state_q == DATA) ? nptr : ptr_q;
    sel  = base;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N;
      if (bus.m_axil_arvalid[idx[IW-1:0]]) sel = idx[IW-1:0];
    end
    onehot = req ? (N'(1) << sel) : '0;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        state_d = req ? ADDR : IDLE;
        grant_d = onehot;
      end
      ADDR: state_d = ar_hs ? DATA : ADDR;
      DATA: if (r_hs) begin
        ptr_d   = nptr;
        grant_d = onehot;
        state_d = req ? ADDR : IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  assign bus.grant_rd       = grant_q;
  assign bus.busy           = state_q != IDLE;
  assign bus.s_axil_arvalid = (state_q == ADDR) & bus.xbar_arvalid;
  assign bus.xbar_arready   = (state_q == ADDR) & bus.s_axil_arready;
  assign bus.xbar_rvalid    = (state_q == DATA) & bus.s_axil_rvalid;
  assign bus.s_axil_rready  = (state_q == DATA) & bus.xbar_rready;
endmodule
